// File: rtl/fft_pkg.sv
// Shared definitions for the FFT16 frame sequencer.
// Provides:
//   N, LOG2N       frame size (fixed at 16 points) and its index width
//   CPLX_W, cplx_t complex sample type {re, im}
//   ctrl_state_e   sequencer states LOAD -> RUN -> CAPTURE -> UNLOAD
//   bitrev4()      4-bit index bit reversal used to reorder output bins
package fft_pkg;

    localparam int N      = 16;
    localparam int LOG2N  = 4;
    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        UNLOAD  = 2'd3
    } ctrl_state_e;

    // Mirror the four index bits: bin 1 (0001) becomes slot 8 (1000).
    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/fft16_frame_buf.sv
// 16-entry complex register file.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (clears all entries)
//   i_wrEn/i_wrIdx/i_wrRe/i_wrIm   single-entry write port
//   i_loadEn/i_loadRe/i_loadIm     whole-frame parallel load (wins over the write port)
//   i_rdIdx -> o_rdRe/o_rdIm       combinational single-entry read
//   o_allRe/o_allIm                whole frame, entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
module fft16_frame_buf
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wrEn,
    input  logic [LOG2N-1:0]        i_wrIdx,
    input  logic [DATA_WIDTH-1:0]   i_wrRe,
    input  logic [DATA_WIDTH-1:0]   i_wrIm,
    input  logic                    i_loadEn,
    input  logic [N*DATA_WIDTH-1:0] i_loadRe,
    input  logic [N*DATA_WIDTH-1:0] i_loadIm,
    input  logic [LOG2N-1:0]        i_rdIdx,
    output logic [DATA_WIDTH-1:0]   o_rdRe,
    output logic [DATA_WIDTH-1:0]   o_rdIm,
    output logic [N*DATA_WIDTH-1:0] o_allRe,
    output logic [N*DATA_WIDTH-1:0] o_allIm
);

    logic [DATA_WIDTH-1:0] r_re [N];
    logic [DATA_WIDTH-1:0] r_im [N];

    // Storage update: a whole-frame load takes priority over a single write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (i_loadEn) begin
            for (int i = 0; i < N; i++) begin
                r_re[i] <= i_loadRe[i*DATA_WIDTH +: DATA_WIDTH];
                r_im[i] <= i_loadIm[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (i_wrEn) begin
            r_re[i_wrIdx] <= i_wrRe;
            r_im[i_wrIdx] <= i_wrIm;
        end
    end

    assign o_rdRe = r_re[i_rdIdx];
    assign o_rdIm = r_im[i_rdIdx];

    // Flatten the register file onto the packed parallel bus.
    always_comb begin
        o_allRe = '0;
        o_allIm = '0;
        for (int i = 0; i < N; i++) begin
            o_allRe[i*DATA_WIDTH +: DATA_WIDTH] = r_re[i];
            o_allIm[i*DATA_WIDTH +: DATA_WIDTH] = r_im[i];
        end
    end

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer around the FFT16 butterfly datapath.
// Collects 16 complex samples (valid/ready), holds them on the FFT16 inputs while
// pulsing its enable for FFT_LATENCY cycles, captures the 16 outputs, then streams
// them out serially in bit-reversed (BIT_REVERSE=1) or natural order.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_s_valid/o_s_ready/i_s_re/i_s_im sample input stream
//   o_m_valid/i_m_ready/o_m_re/o_m_im bin output stream, o_m_idx slot, o_m_last slot 15
//   o_fft_enable, o_fft_zr/o_fft_zi   FFT16 enable and parallel inputs
//   i_fft_Zr/i_fft_Zi                 FFT16 parallel outputs
//   o_busy                            high outside LOAD
//   o_frame_done                      one-cycle pulse after the final bin is accepted
module fft16_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 16,
    parameter int FFT_LATENCY = 4,
    parameter bit BIT_REVERSE = 1'b1
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_s_valid,
    output logic                    o_s_ready,
    input  logic [DATA_WIDTH-1:0]   i_s_re,
    input  logic [DATA_WIDTH-1:0]   i_s_im,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic [DATA_WIDTH-1:0]   o_m_re,
    output logic [DATA_WIDTH-1:0]   o_m_im,
    output logic [3:0]              o_m_idx,
    output logic                    o_m_last,
    output logic                    o_fft_enable,
    output logic [N*DATA_WIDTH-1:0] o_fft_zr,
    output logic [N*DATA_WIDTH-1:0] o_fft_zi,
    input  logic [N*DATA_WIDTH-1:0] i_fft_Zr,
    input  logic [N*DATA_WIDTH-1:0] i_fft_Zi,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int RUN_W = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

    if (N != fft_pkg::N) begin : gBadN
        $error("fft16_frame_ctrl supports N=16 only");
    end
    if (FFT_LATENCY < 1) begin : gBadLatency
        $error("fft16_frame_ctrl needs FFT_LATENCY >= 1");
    end

    ctrl_state_e      r_state;
    logic [LOG2N-1:0] r_wrCnt;
    logic [LOG2N-1:0] r_rdCnt;
    logic [RUN_W-1:0] r_runCnt;
    logic             r_sReady;
    logic             r_mValid;
    logic             r_fftEnable;
    logic             r_busy;
    logic             r_frameDone;

    logic             w_inHs;
    logic             w_outHs;
    logic             w_obufLoad;
    logic [LOG2N-1:0] w_rdIdx;
    logic [DATA_WIDTH-1:0]   w_unusedIbufRe;
    logic [DATA_WIDTH-1:0]   w_unusedIbufIm;
    logic [N*DATA_WIDTH-1:0] w_unusedObufRe;
    logic [N*DATA_WIDTH-1:0] w_unusedObufIm;

    // r_sReady is only ever high in LOAD, so it doubles as the LOAD qualifier.
    assign w_inHs     = i_s_valid && r_sReady;
    assign w_outHs    = r_mValid && i_m_ready;
    assign w_obufLoad = (r_state == CAPTURE);
    assign w_rdIdx    = BIT_REVERSE ? bitrev4(r_rdCnt) : r_rdCnt;

    fft16_frame_buf #(.DATA_WIDTH(DATA_WIDTH)) u_ibuf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wrEn   (w_inHs),
        .i_wrIdx  (r_wrCnt),
        .i_wrRe   (i_s_re),
        .i_wrIm   (i_s_im),
        .i_loadEn (1'b0),
        .i_loadRe ('0),
        .i_loadIm ('0),
        .i_rdIdx  ('0),
        .o_rdRe   (w_unusedIbufRe),
        .o_rdIm   (w_unusedIbufIm),
        .o_allRe  (o_fft_zr),
        .o_allIm  (o_fft_zi)
    );

    fft16_frame_buf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wrEn   (1'b0),
        .i_wrIdx  ('0),
        .i_wrRe   ('0),
        .i_wrIm   ('0),
        .i_loadEn (w_obufLoad),
        .i_loadRe (i_fft_Zr),
        .i_loadIm (i_fft_Zi),
        .i_rdIdx  (w_rdIdx),
        .o_rdRe   (o_m_re),
        .o_rdIm   (o_m_im),
        .o_allRe  (w_unusedObufRe),
        .o_allIm  (w_unusedObufIm)
    );

    // Sequencer: all handshake-facing flags are registered alongside the state so
    // they change exactly on the transition edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= LOAD;
            r_wrCnt     <= '0;
            r_rdCnt     <= '0;
            r_runCnt    <= '0;
            r_sReady    <= 1'b1;
            r_mValid    <= 1'b0;
            r_fftEnable <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_inHs) begin
                        if (r_wrCnt == LOG2N'(N-1)) begin
                            r_wrCnt     <= '0;
                            r_runCnt    <= '0;
                            r_sReady    <= 1'b0;
                            r_busy      <= 1'b1;
                            r_fftEnable <= 1'b1;
                            r_state     <= RUN;
                        end else begin
                            r_wrCnt <= r_wrCnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_runCnt == RUN_W'(FFT_LATENCY-1)) begin
                        r_fftEnable <= 1'b0;
                        r_state     <= CAPTURE;
                    end else begin
                        r_runCnt <= r_runCnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_mValid <= 1'b1;
                    r_state  <= UNLOAD;
                end
                UNLOAD: begin
                    if (w_outHs) begin
                        if (r_rdCnt == LOG2N'(N-1)) begin
                            r_rdCnt     <= '0;
                            r_mValid    <= 1'b0;
                            r_sReady    <= 1'b1;
                            r_busy      <= 1'b0;
                            r_frameDone <= 1'b1;
                            r_state     <= LOAD;
                        end else begin
                            r_rdCnt <= r_rdCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign o_s_ready    = r_sReady;
    assign o_m_valid    = r_mValid;
    assign o_m_idx      = r_rdCnt;
    assign o_m_last     = (r_rdCnt == LOG2N'(N-1));
    assign o_fft_enable = r_fftEnable;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Self-checking bench for fft16_frame_ctrl.
// Two instances share one stimulus stream: inst 0 with BIT_REVERSE=1, inst 1 with
// BIT_REVERSE=0. Each drives its own behavioural FFT16 stub (Zr[k]=zr[k]+k, Zi[k]=zi[k]
// after FFT_LATENCY enabled edges). Expected bins go into per-instance queues when a
// frame finishes loading; a monitor pops and compares on every output handshake.
module tb_fft16_frame_ctrl;
    import fft_pkg::*;

    localparam int DW  = 16;
    localparam int LAT = 4;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          sValid = 1'b0;
    logic [DW-1:0] sRe    = '0;
    logic [DW-1:0] sIm    = '0;
    logic          mReady = 1'b0;
    bit            readyRandom = 1'b0;

    logic          sReady    [2];
    logic          mValid    [2];
    logic [DW-1:0] mRe       [2];
    logic [DW-1:0] mIm       [2];
    logic [3:0]    mIdx      [2];
    logic          mLast     [2];
    logic          fftEn     [2];
    logic          busy      [2];
    logic          frameDone [2];
    logic [16*DW-1:0] fftZr  [2];
    logic [16*DW-1:0] fftZi  [2];
    logic [16*DW-1:0] stubZr [2];
    logic [16*DW-1:0] stubZi [2];
    int               enCnt  [2];

    cplx_t frame [16];
    exp_t  expQ0 [$];
    exp_t  expQ1 [$];
    exp_t  popped;

    int  compared   = 0;
    int  mismatched = 0;
    int  doneCount   [2];
    bit  pendingDone [2];
    bit  prevStall   [2];
    logic [63:0] prevWord [2];

    fft16_frame_ctrl #(.DATA_WIDTH(DW), .N(16), .FFT_LATENCY(LAT), .BIT_REVERSE(1'b1)) dut0 (
        .i_clk(clock), .i_rst(reset),
        .i_s_valid(sValid), .o_s_ready(sReady[0]), .i_s_re(sRe), .i_s_im(sIm),
        .o_m_valid(mValid[0]), .i_m_ready(mReady), .o_m_re(mRe[0]), .o_m_im(mIm[0]),
        .o_m_idx(mIdx[0]), .o_m_last(mLast[0]),
        .o_fft_enable(fftEn[0]), .o_fft_zr(fftZr[0]), .o_fft_zi(fftZi[0]),
        .i_fft_Zr(stubZr[0]), .i_fft_Zi(stubZi[0]),
        .o_busy(busy[0]), .o_frame_done(frameDone[0])
    );

    fft16_frame_ctrl #(.DATA_WIDTH(DW), .N(16), .FFT_LATENCY(LAT), .BIT_REVERSE(1'b0)) dut1 (
        .i_clk(clock), .i_rst(reset),
        .i_s_valid(sValid), .o_s_ready(sReady[1]), .i_s_re(sRe), .i_s_im(sIm),
        .o_m_valid(mValid[1]), .i_m_ready(mReady), .o_m_re(mRe[1]), .o_m_im(mIm[1]),
        .o_m_idx(mIdx[1]), .o_m_last(mLast[1]),
        .o_fft_enable(fftEn[1]), .o_fft_zr(fftZr[1]), .o_fft_zi(fftZi[1]),
        .i_fft_Zr(stubZr[1]), .i_fft_Zi(stubZi[1]),
        .o_busy(busy[1]), .o_frame_done(frameDone[1])
    );

    // FFT16 stand-in: intermediate enabled edges scribble junk on the outputs so an
    // early capture or an extra enable shows up as corrupted bins.
    initial begin
        for (int i = 0; i < 2; i++) begin
            stubZr[i] = '0;
            stubZi[i] = '0;
            enCnt[i]  = 0;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (fftEn[i]) begin
                if (enCnt[i] == LAT-1) begin
                    enCnt[i] <= 0;
                    for (int k = 0; k < 16; k++) begin
                        stubZr[i][k*DW +: DW] <= fftZr[i][k*DW +: DW] + 16'(k);
                        stubZi[i][k*DW +: DW] <= fftZi[i][k*DW +: DW];
                    end
                end else begin
                    enCnt[i]  <= enCnt[i] + 1;
                    stubZr[i] <= {16{16'hDEAD}};
                    stubZi[i] <= {16{16'hBEEF}};
                end
            end else begin
                enCnt[i] <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic int bitrevModel(input int j);
        int rev = 0;
        for (int b = 0; b < 4; b++)
            if (((j >> b) & 1) == 1) rev += (8 >> b);
        return rev;
    endfunction

    // Reference: bin b = (re[b] + b, im[b]); slot j of inst 0 carries bin bitrev(j),
    // slot j of inst 1 carries bin j.
    task automatic pushExpected();
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            int b0 = bitrevModel(j);
            e.idx  = 4'(j);
            e.last = (j == 15);
            e.re   = 16'(frame[b0].re) + 16'(b0);
            e.im   = frame[b0].im;
            expQ0.push_back(e);
            e.re   = 16'(frame[j].re) + 16'(j);
            e.im   = frame[j].im;
            expQ1.push_back(e);
        end
    endtask

    function automatic int qSize(input int i);
        return (i == 0) ? expQ0.size() : expQ1.size();
    endfunction

    // Output monitor: decoupled from stimulus, compares every accepted bin, checks
    // stability under stall, enable quiet during UNLOAD, and the frame_done pulse.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                pendingDone[i] = 1'b0;
                prevStall[i]   = 1'b0;
            end else begin
                if (pendingDone[i] || frameDone[i]) begin
                    checkOutput("frame_done", 64'(frameDone[i]), 64'(pendingDone[i]));
                    if (frameDone[i]) begin
                        doneCount[i]++;
                        checkOutput("s_ready_at_done", 64'(sReady[i]), 64'd1);
                    end
                end
                pendingDone[i] = 1'b0;
                if (mValid[i]) begin
                    checkOutput("enable_in_unload", 64'(fftEn[i]), 64'd0);
                    if (prevStall[i])
                        checkOutput("stall_stable", 64'({mRe[i], mIm[i], mIdx[i]}), prevWord[i]);
                    if (mReady) begin
                        if (qSize(i) == 0) begin
                            checkOutput("unexpected_bin", 64'(mIdx[i]), 64'hFFFF);
                        end else begin
                            popped = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
                            checkOutput($sformatf("bin_inst%0d", i),
                                        64'({mRe[i], mIm[i], mIdx[i], mLast[i]}),
                                        64'({popped.re, popped.im, popped.idx, popped.last}));
                            pendingDone[i] = popped.last;
                        end
                    end
                    prevStall[i] = !mReady;
                    prevWord[i]  = 64'({mRe[i], mIm[i], mIdx[i]});
                end else begin
                    prevStall[i] = 1'b0;
                end
            end
        end
    end

    // Output-side ready: held high, or a fair coin each cycle.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            mReady = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic doReset();
        reset  = 1'b1;
        sValid = 1'b0;
        expQ0.delete();
        expQ1.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_m_valid",    64'(mValid[i]),    64'd0);
            checkOutput("rst_s_ready",    64'(sReady[i]),    64'd1);
            checkOutput("rst_enable",     64'(fftEn[i]),     64'd0);
            checkOutput("rst_busy",       64'(busy[i]),      64'd0);
            checkOutput("rst_frame_done", 64'(frameDone[i]), 64'd0);
            checkOutput("rst_m_outputs",  64'({mRe[i], mIm[i], mIdx[i], mLast[i]}), 64'd0);
        end
    endtask

    // Sends the first nSamples of frame[]; a full frame also queues the expected
    // bins and checks the RUN/CAPTURE timeline cycle by cycle.
    task automatic applyStimulus(input int nSamples, input bit gaps);
        int sent   = 0;
        int budget = 0;
        bit toggle = 1'b0;
        bit hs;
        logic [16*DW-1:0] packRe;
        logic [16*DW-1:0] packIm;
        while (sent < nSamples && budget < 500) begin
            toggle = ~toggle;
            sValid = gaps ? toggle : 1'b1;
            sRe    = frame[sent].re;
            sIm    = frame[sent].im;
            hs     = sValid && sReady[0];
            if (hs && sent == 15)
                checkOutput("busy_before_last", 64'(busy[0]), 64'd0);
            @(posedge clock);
            #1;
            if (hs) sent++;
            budget++;
        end
        sValid = 1'b0;
        if (sent < nSamples) begin
            checkOutput("load_timeout", 64'(sent), 64'(nSamples));
            return;
        end
        if (nSamples != 16) return;
        pushExpected();
        for (int k = 0; k < 16; k++) begin
            packRe[k*DW +: DW] = frame[k].re;
            packIm[k*DW +: DW] = frame[k].im;
        end
        for (int t = 1; t <= 6; t++) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("enable_c+%0d", t), 64'(fftEn[i]), 64'(t <= LAT));
                checkOutput($sformatf("m_valid_c+%0d", t), 64'(mValid[i]), 64'(t == LAT + 2));
                checkOutput($sformatf("s_ready_c+%0d", t), 64'(sReady[i]), 64'd0);
                checkOutput($sformatf("busy_c+%0d", t), 64'(busy[i]), 64'd1);
                if (t <= LAT) begin
                    checkOutput("zr_frame", 64'(fftZr[i] != packRe), 64'd0);
                    checkOutput("zi_frame", 64'(fftZi[i] != packIm), 64'd0);
                end
            end
            if (t < 6) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic waitFrameDone(input int target);
        int budget = 0;
        while ((doneCount[0] < target || doneCount[1] < target) && budget < 2000) begin
            @(posedge clock);
            #1;
            budget++;
        end
        checkOutput("done_count_inst0", 64'(doneCount[0]), 64'(target));
        checkOutput("done_count_inst1", 64'(doneCount[1]), 64'(target));
        checkOutput("queue_drained", 64'(qSize(0) + qSize(1)), 64'd0);
    endtask

    task automatic fillRamp();
        for (int k = 0; k < 16; k++) begin
            frame[k].re = 16'(k);
            frame[k].im = '0;
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 16; k++) begin
            frame[k].re = 16'($urandom);
            frame[k].im = 16'($urandom);
        end
    endtask

    initial begin
        int budget;
        doneCount[0] = 0;
        doneCount[1] = 0;
        repeat (2) @(posedge clock);
        #1;
        doReset();

        // Ramp, ready held high: slot j of inst 0 carries 2*bitrev(j).
        readyRandom = 1'b0;
        fillRamp();
        applyStimulus(16, 1'b0);
        waitFrameDone(1);

        // Random data under random backpressure.
        readyRandom = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fillRandom();
            applyStimulus(16, 1'b0);
            waitFrameDone(2 + f);
        end

        // Input gaps every other cycle.
        readyRandom = 1'b0;
        fillRamp();
        applyStimulus(16, 1'b1);
        waitFrameDone(4);

        // Reset after 7 samples discards the partial frame.
        fillRandom();
        applyStimulus(7, 1'b0);
        doReset();
        fillRandom();
        applyStimulus(16, 1'b0);
        waitFrameDone(5);

        // Reset in the middle of UNLOAD at slot 5.
        readyRandom = 1'b1;
        fillRandom();
        applyStimulus(16, 1'b0);
        budget = 0;
        while (!(mValid[0] && mIdx[0] == 4'd5) && budget < 500) begin
            @(posedge clock);
            #1;
            budget++;
        end
        checkOutput("reached_slot5", 64'(mIdx[0]), 64'd5);
        doReset();
        fillRandom();
        applyStimulus(16, 1'b0);
        waitFrameDone(6);

        // Impulse frame in both orderings.
        readyRandom = 1'b0;
        for (int k = 0; k < 16; k++) begin
            frame[k].re = '0;
            frame[k].im = '0;
        end
        frame[0].re = 16'sd1000;
        applyStimulus(16, 1'b0);
        waitFrameDone(7);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
